frame_sync_controller: RTL and testbench

- Per-frame sequencer between the camera/hand-tracking sources and game_logic_and_renderer, in the 65 MHz pixel domain.
- At the start of vertical blanking it snapshots all tracked points into shadow registers, so the renderer sees coordinates that stay constant for the whole frame.
- It then issues one game-update tick and waits for the game logic to acknowledge it, with a timeout.
- It also counts frames and reports missed or overrun ticks for debug LEDs.

---
 rtl/huah_pkg.sv | 21 ++
 rtl/sat_counter.sv | 31 +++
 rtl/frame_sync_controller.sv | 112 +++++++++++
 tb/tb_frame_sync_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huah_pkg.sv
// Shared types and constants for the hand-tracking frame pipeline.
// Point layout is {x, y, z}; point 0 of a packed point vector sits in the LSBs.
package huah_pkg;
   localparam int NUM_POINTS = 5;
   localparam int POINT_W    = 38;
   localparam int H_ACTIVE   = 1024;
   localparam int V_ACTIVE   = 768;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [13:0] z;
   } point_t;

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      TICK,
      WAIT_DONE
   } fsc_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
// Count is registered: an increment shows one cycle later; clear beats increment.
module sat_counter #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             clr_in,
   input  logic             inc_in,
   output logic [WIDTH-1:0] count_out
);
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr_in) begin
         count_d = '0;
      end else if (inc_in && !(SATURATE && (count_q == '1))) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_out = count_q;
endmodule

// File: rtl/frame_sync_controller.sv
// Per-frame sequencer: snapshot points at vblank start, issue one game tick, wait for done or timeout.
// Snapshot and tick appear 2 cycles after the frame edge; frame edges arriving while busy are dropped and counted.
module frame_sync_controller #(
   parameter int V_ACTIVE       = huah_pkg::V_ACTIVE,
   parameter int NUM_POINTS     = huah_pkg::NUM_POINTS,
   parameter int POINT_W        = huah_pkg::POINT_W,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [10:0]                   hcount_in,
   input  logic [9:0]                    vcount_in,
   input  logic [NUM_POINTS*POINT_W-1:0] points_in,
   input  logic                          points_valid_in,
   input  logic                          pause_in,
   input  logic                          tick_done_in,
   output logic [NUM_POINTS*POINT_W-1:0] points_out,
   output logic                          tick_out,
   output logic                          busy_out,
   output logic [15:0]                   frame_count_out,
   output logic [7:0]                    missed_frames_out,
   output logic                          overrun_out
);
   localparam int             TW           = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   huah_pkg::fsc_state_t state_d, state_q;
   logic [NUM_POINTS*POINT_W-1:0] points_d, points_q;
   logic                          tick_d, tick_q;
   logic                          overrun_d, overrun_q;
   logic [15:0]                   frame_d, frame_q;
   logic                          frame_edge;
   logic [TW-1:0]                 wait_cnt;
   logic                          timeout_hit;

   assign frame_edge  = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
   assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

   // Restarted from zero in TICK so every WAIT_DONE gets the full budget.
   sat_counter #(.WIDTH(TW), .SATURATE(1'b1)) u_timeout (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr_in    (state_q == huah_pkg::TICK),
      .inc_in    (state_q == huah_pkg::WAIT_DONE),
      .count_out (wait_cnt)
   );

   sat_counter #(.WIDTH(8), .SATURATE(1'b1)) u_missed (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr_in    (1'b0),
      .inc_in    (frame_edge && (state_q != huah_pkg::IDLE)),
      .count_out (missed_frames_out)
   );

   always_comb begin
      state_d   = state_q;
      points_d  = points_q;
      tick_d    = 1'b0;
      overrun_d = overrun_q;
      frame_d   = frame_q + 16'(frame_edge);
      case (state_q)
         huah_pkg::IDLE: begin
            if (frame_edge) state_d = huah_pkg::LATCH;
         end
         huah_pkg::LATCH: begin
            if (points_valid_in) points_d = points_in;
            if (pause_in) begin
               state_d = huah_pkg::IDLE;
            end else begin
               state_d = huah_pkg::TICK;
               tick_d  = 1'b1;
            end
         end
         huah_pkg::TICK: begin
            state_d = huah_pkg::WAIT_DONE;
         end
         huah_pkg::WAIT_DONE: begin
            // A done in the final budget cycle still counts as on time.
            if (tick_done_in) begin
               state_d = huah_pkg::IDLE;
            end else if (timeout_hit) begin
               overrun_d = 1'b1;
               state_d   = huah_pkg::IDLE;
            end
         end
         default: state_d = huah_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= huah_pkg::IDLE;
         points_q  <= '0;
         tick_q    <= 1'b0;
         overrun_q <= 1'b0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         points_q  <= points_d;
         tick_q    <= tick_d;
         overrun_q <= overrun_d;
         frame_q   <= frame_d;
      end
   end

   assign points_out      = points_q;
   assign tick_out        = tick_q;
   assign busy_out        = (state_q != huah_pkg::IDLE);
   assign frame_count_out = frame_q;
   assign overrun_out     = overrun_q;
endmodule

// File: tb/tb_frame_sync_controller.sv
// Bench for frame_sync_controller: directed scenarios plus random traffic against a timeline model.
module tb_frame_sync_controller;
   localparam int T  = 16;
   localparam int VA = 768;
   localparam int W  = 5 * 38;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [10:0]   hcount = 11'd5;
   logic [9:0]    vcount = 10'd0;
   logic [W-1:0]  pts_in = '0;
   logic          pvalid = 1'b0;
   logic          pause = 1'b0;
   logic          done = 1'b0;
   logic [W-1:0]  points_out;
   logic          tick_out;
   logic          busy_out;
   logic [15:0]   frame_count_out;
   logic [7:0]    missed_frames_out;
   logic          overrun_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a sequence is tracked only by how many cycles ago its frame edge was.
   logic [W-1:0] m_pts;
   logic [15:0]  m_frames;
   int           m_missed;
   bit           m_over;
   bit           m_tick;
   bit           m_active;
   int           m_phase;

   always #5 clk = ~clk;

   frame_sync_controller #(.V_ACTIVE(VA), .NUM_POINTS(5), .POINT_W(38), .TIMEOUT_CYCLES(T)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .hcount_in         (hcount),
      .vcount_in         (vcount),
      .points_in         (pts_in),
      .points_valid_in   (pvalid),
      .pause_in          (pause),
      .tick_done_in      (done),
      .points_out        (points_out),
      .tick_out          (tick_out),
      .busy_out          (busy_out),
      .frame_count_out   (frame_count_out),
      .missed_frames_out (missed_frames_out),
      .overrun_out       (overrun_out)
   );

   function automatic logic [W-1:0] rand_pts();
      logic [W-1:0] v = '0;
      for (int i = 0; i < 7; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   task automatic set_edge(input bit e);
      if (e) begin
         hcount = 11'd0;
         vcount = 10'(VA);
      end else begin
         hcount = 11'($urandom_range(1, 1343));
         vcount = 10'($urandom_range(0, 805));
      end
   endtask

   // One clock: the model consumes the inputs seen at this edge; outputs are sampled 1 time unit later.
   task automatic step();
      bit fe;
      @(posedge clk);
      fe = (hcount == 11'd0) && (vcount == 10'(VA));
      if (rst) begin
         m_pts = '0; m_frames = '0; m_missed = 0; m_over = 0; m_tick = 0; m_active = 0; m_phase = 0;
      end else begin
         m_tick = 0;
         if (fe) m_frames = m_frames + 16'd1;
         if (m_active) begin
            if (fe && m_missed < 255) m_missed++;
            if (m_phase == 1) begin
               if (pvalid) m_pts = pts_in;
               if (pause) m_active = 0;
               else m_tick = 1;
            end else if (m_phase >= 3) begin
               if (done) m_active = 0;
               else if (m_phase == T + 2) begin
                  m_over = 1;
                  m_active = 0;
               end
            end
            m_phase++;
         end else if (fe) begin
            m_active = 1;
            m_phase = 1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; done = 1'b0; pause = 1'b0; pvalid = 1'b0;
      set_edge(0);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pts_in = rand_pts();
      do_reset();
      n_checks++; if (points_out !== '0) begin n_fail++; $display("FAIL reset_points got=%h exp=0", points_out); end
      n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
      n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
      n_checks++; if (frame_count_out !== 16'd0) begin n_fail++; $display("FAIL reset_frames got=%0d exp=0", frame_count_out); end
      n_checks++; if (missed_frames_out !== 8'd0) begin n_fail++; $display("FAIL reset_missed got=%0d exp=0", missed_frames_out); end
      n_checks++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun_out); end
   endtask

   // Edge at cycle e with pattern A; done in cycle e+10. After step k the sampled cycle is e+k+1.
   task automatic test_basic(output logic [W-1:0] a);
      a = rand_pts();
      pts_in = a; pvalid = 1'b1; pause = 1'b0;
      set_edge(1);
      step();
      n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL basic_busy_latch got=%b exp=1", busy_out); end
      for (int k = 1; k <= 14; k++) begin
         set_edge(0);
         done = (k == 10);
         step();
         n_checks++; if (tick_out !== (k + 1 == 2)) begin n_fail++; $display("FAIL basic_tick cyc=e+%0d got=%b exp=%b", k + 1, tick_out, k + 1 == 2); end
         n_checks++; if (busy_out !== (k + 1 <= 10)) begin n_fail++; $display("FAIL basic_busy cyc=e+%0d got=%b exp=%b", k + 1, busy_out, k + 1 <= 10); end
         if (k + 1 == 2) begin
            n_checks++; if (points_out !== a) begin n_fail++; $display("FAIL basic_points got=%h exp=%h", points_out, a); end
         end
      end
      done = 1'b0;
      n_checks++; if (frame_count_out !== 16'd1) begin n_fail++; $display("FAIL basic_frames got=%0d exp=1", frame_count_out); end
      n_checks++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got=%b exp=0", overrun_out); end
   endtask

   task automatic test_invalid_hold(input logic [W-1:0] a);
      pts_in = rand_pts(); pvalid = 1'b0;
      set_edge(1);
      step();
      for (int k = 1; k <= 8; k++) begin
         set_edge(0);
         done = (k == 5);
         step();
         n_checks++; if (tick_out !== (k + 1 == 2)) begin n_fail++; $display("FAIL hold_tick cyc=e+%0d got=%b exp=%b", k + 1, tick_out, k + 1 == 2); end
         n_checks++; if (points_out !== a) begin n_fail++; $display("FAIL hold_points got=%h exp=%h", points_out, a); end
      end
      done = 1'b0;
   endtask

   task automatic test_pause();
      logic [W-1:0] p;
      do_reset();
      pause = 1'b1; pvalid = 1'b1;
      for (int f = 0; f < 3; f++) begin
         p = rand_pts();
         pts_in = p;
         set_edge(1);
         step();
         for (int k = 0; k < 5; k++) begin
            set_edge(0);
            step();
            n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL pause_tick frame=%0d got=%b exp=0", f, tick_out); end
         end
         n_checks++; if (points_out !== p) begin n_fail++; $display("FAIL pause_points frame=%0d got=%h exp=%h", f, points_out, p); end
      end
      pause = 1'b0;
      n_checks++; if (frame_count_out !== 16'd3) begin n_fail++; $display("FAIL pause_frames got=%0d exp=3", frame_count_out); end
      n_checks++; if (missed_frames_out !== 8'd0) begin n_fail++; $display("FAIL pause_missed got=%0d exp=0", missed_frames_out); end
   endtask

   // WAIT_DONE spans cycles e+3..e+2+T, so overrun is first visible at e+3+T.
   task automatic test_timeout();
      do_reset();
      pvalid = 1'b1; pts_in = rand_pts();
      set_edge(1);
      step();
      for (int k = 1; k <= T + 5; k++) begin
         set_edge(0);
         step();
         n_checks++; if (overrun_out !== (k + 1 >= T + 3)) begin n_fail++; $display("FAIL timeout_overrun cyc=e+%0d got=%b exp=%b", k + 1, overrun_out, k + 1 >= T + 3); end
         n_checks++; if (busy_out !== (k + 1 <= T + 2)) begin n_fail++; $display("FAIL timeout_busy cyc=e+%0d got=%b exp=%b", k + 1, busy_out, k + 1 <= T + 2); end
      end
      set_edge(1);
      step();
      set_edge(0);
      step();
      n_checks++; if (tick_out !== 1'b1) begin n_fail++; $display("FAIL timeout_next_tick got=%b exp=1", tick_out); end
      n_checks++; if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", overrun_out); end
      for (int k = 0; k < 4; k++) begin
         done = (k == 1);
         step();
      end
      done = 1'b0;
   endtask

   // Continuous frame edges: every edge while busy is dropped and counted.
   task automatic test_saturate();
      do_reset();
      pvalid = 1'b1;
      set_edge(1);
      for (int i = 0; i < 301; i++) step();
      set_edge(0);
      n_checks++; if (missed_frames_out !== 8'd255) begin n_fail++; $display("FAIL sat_missed got=%0d exp=255", missed_frames_out); end
      n_checks++; if (frame_count_out !== 16'd301) begin n_fail++; $display("FAIL sat_frames got=%0d exp=301", frame_count_out); end
      n_checks++; if (missed_frames_out !== 8'(m_missed)) begin n_fail++; $display("FAIL sat_missed_model got=%0d exp=%0d", missed_frames_out, m_missed); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pvalid = 1'b1; pts_in = rand_pts();
      set_edge(1);
      step();
      set_edge(0);
      for (int k = 0; k < 4; k++) step();
      n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got=%b exp=1", busy_out); end
      rst = 1'b1;
      step();
      rst = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if ({points_out, tick_out, busy_out, frame_count_out, missed_frames_out, overrun_out} !== '0)
            begin n_fail++; $display("FAIL rmid_outputs cyc=%0d got busy=%b tick=%b frames=%0d missed=%0d over=%b exp all 0", k, busy_out, tick_out, frame_count_out, missed_frames_out, overrun_out); end
      end
   endtask

   // Done during TICK is ignored; done in the last budget cycle wins over timeout.
   task automatic test_done_at_timeout();
      do_reset();
      pvalid = 1'b1; pts_in = rand_pts();
      set_edge(1);
      step();
      for (int k = 1; k <= T + 4; k++) begin
         set_edge(0);
         done = (k == 2) || (k == T + 2);
         step();
         n_checks++; if (busy_out !== (k + 1 <= T + 2)) begin n_fail++; $display("FAIL dto_busy cyc=e+%0d got=%b exp=%b", k + 1, busy_out, k + 1 <= T + 2); end
      end
      done = 1'b0;
      n_checks++; if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL dto_overrun got=%b exp=0", overrun_out); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) pause = ~pause;
         set_edge($urandom_range(0, 24) == 0);
         pvalid = ($urandom_range(0, 3) != 0);
         done   = ($urandom_range(0, 13) == 0);
         rst    = ($urandom_range(0, 699) == 0);
         pts_in = rand_pts();
         step();
         n_checks++; if (points_out !== m_pts) begin n_fail++; $display("FAIL rnd_points c=%0d got=%h exp=%h", c, points_out, m_pts); end
         n_checks++; if (tick_out !== m_tick) begin n_fail++; $display("FAIL rnd_tick c=%0d got=%b exp=%b", c, tick_out, m_tick); end
         n_checks++; if (busy_out !== m_active) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_out, m_active); end
         n_checks++; if (frame_count_out !== m_frames) begin n_fail++; $display("FAIL rnd_frames c=%0d got=%0d exp=%0d", c, frame_count_out, m_frames); end
         n_checks++; if (missed_frames_out !== 8'(m_missed)) begin n_fail++; $display("FAIL rnd_missed c=%0d got=%0d exp=%0d", c, missed_frames_out, m_missed); end
         n_checks++; if (overrun_out !== m_over) begin n_fail++; $display("FAIL rnd_overrun c=%0d got=%b exp=%b", c, overrun_out, m_over); end
      end
      rst = 1'b0; done = 1'b0; pause = 1'b0;
   endtask

   initial begin
      logic [W-1:0] pat_a;
      test_reset();
      test_basic(pat_a);
      test_invalid_hold(pat_a);
      test_pause();
      test_timeout();
      test_saturate();
      test_reset_mid();
      test_done_at_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
